digit_argmax: RTL and testbench
===============================

DIGIT_ARGMAX -- requirements
Module: digit_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10: number of output-layer scores per frame, range 2..16.
REQ-002 Parameter SCORE_W, default 16: score width, two's-complement signed.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous discard of the partial frame or held result.
REQ-006 in_valid  input  1  in_score is valid this cycle.
REQ-007 in_ready  output  1  block accepts a score this cycle.
REQ-008 in_score  input  SCORE_W  one output-layer neuron score, class order 0..NUM_CLASSES-1.
REQ-009 out_valid  output  1  classification result held on the out_* outputs.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_digit  output  4  index of the maximum score.
REQ-012 out_score  output  SCORE_W  maximum score value.
REQ-013 out_margin  output  SCORE_W  top score minus second-highest score; present only with the macro in REQ-032.
REQ-014 frame_cnt  output  16  count of completed frames.

Function
REQ-015 FSM states: ACCUM and HOLD; reset state is ACCUM.
REQ-016 ACCUM: in_ready=1, out_valid=0; a transfer occurs when in_valid && in_ready.
REQ-017 Internal class index counter: 0 at frame start, +1 per transfer.
REQ-018 Transfer at index 0: loads the running max and out_digit=0 unconditionally.
REQ-019 Transfer at index k>0: replaces the max and digit only if in_score > max (signed, strict); a tie keeps the lower index.
REQ-020 Transfer at index NUM_CLASSES-1: goes to HOLD next cycle; out_valid=1 exactly one cycle after the last transfer.
REQ-021 HOLD: in_ready=0; out_digit, out_score and out_margin are stable until handshake.
REQ-022 HOLD with out_ready=1: handshake; next cycle ACCUM, index 0, frame_cnt+1.
REQ-023 frame_cnt wraps 0xFFFF -> 0x0000.
REQ-024 out_valid=1 and out_ready=0: outputs held indefinitely; no score accepted.
REQ-025 flush=1 in ACCUM: index cleared to 0; any same-cycle score is discarded (flush wins).
REQ-026 flush=1 in HOLD: result dropped; next cycle ACCUM, out_valid=0, frame_cnt unchanged.
REQ-027 flush has priority over an out handshake in the same cycle.
REQ-028 in_valid is ignored while in_ready=0; no combinational path from in_valid to in_ready.

Reset
REQ-029 rst_n=0 immediately forces: state ACCUM, index 0, out_valid 0, out_digit 0, out_score 0, out_margin 0, frame_cnt 0.
REQ-030 Reset mid-frame or in HOLD discards all partial or held data; the first transfer after release is class 0.
REQ-031 in_ready=1 in the first cycle after reset release.

Configuration
REQ-032 Macro ARGMAX_MARGIN_EN defined: the block tracks the second-highest score.
- A new maximum demotes the old max to second.
- Otherwise, a score greater than second replaces second.
- out_margin = max - second, unsigned, saturating at 2^SCORE_W-1.
REQ-033 Macro ARGMAX_MARGIN_EN undefined: out_margin and the second-max register are absent; all other behaviour is identical.

Verification
REQ-034 Scores 5,3,9,1,0,2,8,7,6,4 (class order), out_ready=1 -> out_digit=2, out_score=9, out_margin=1 (macro on), frame_cnt=1.
REQ-035 All ten scores equal to -100 (0xFF9C) -> out_digit=0, out_score=0xFF9C, out_margin=0.
REQ-036 Scores -32768 at class 0, 32767 at class 9, others 0, macro on -> out_digit=9, out_margin=0x7FFF; a max/second pair differing by more than 2^SCORE_W-1 saturates out_margin to 0xFFFF.
REQ-037 out_ready=0 for 20 cycles after a result -> out_valid and outputs stable, in_ready=0; on release, the next frame is accepted the cycle after the handshake.
REQ-038 flush after 4 scores, then a full frame with max at class 6 -> out_digit=6; frame_cnt increments only once.
REQ-039 rst_n pulsed low during class 5 of a frame -> outputs at reset values; the following full frame classifies correctly.

Source files
------------

// File: rtl/digit_argmax.sv
// digit_argmax: streaming argmax over one frame of NUM_CLASSES signed scores.
// Scores arrive in class order 0..NUM_CLASSES-1; after the last one the
// winning class index and its score are held on out_* until taken.
// Optional feature macro: ARGMAX_MARGIN_EN adds second-max tracking and the
// out_margin port (top score minus runner-up, unsigned, saturating).
//
// Handshake: a score is taken on a rising edge where in_valid && in_ready
// (and flush is low); a result is taken on a rising edge where
// out_valid && out_ready (and flush is low). in_ready depends only on state,
// never on in_valid. Once out_valid rises, out_* stay stable until taken.
module digit_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_digit,
  output logic [SCORE_W-1:0] out_score,
`ifdef ARGMAX_MARGIN_EN
  output logic [SCORE_W-1:0] out_margin,
`endif
  output logic [15:0]        frame_cnt,
  output logic               dbg_state
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [SCORE_W-1:0] max_q, max_d;
  logic [3:0]         digit_q, digit_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               accept;
  logic               last;

`ifdef ARGMAX_MARGIN_EN
  localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  logic [SCORE_W-1:0]   second_q, second_d;
  logic [SCORE_W+1:0]   diff;
`endif

  // FSM next state and handshake outputs; flush always returns to ACCUM
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    accept    = (state_q == ACCUM) && in_valid && !flush;
    last      = (idx_q == LAST_IDX);
    case (state_q)
      ACCUM: if (accept && last) state_d = HOLD;
      HOLD:  if (flush || out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Running max, class index and completed-frame counter
  always_comb begin
    idx_d   = idx_q;
    max_d   = max_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
`ifdef ARGMAX_MARGIN_EN
    second_d = second_q;
`endif
    if (flush) begin
      idx_d = 4'd0;
    end else if (accept) begin
      if (idx_q == 4'd0) begin
        // first class of a frame loads unconditionally
        max_d   = in_score;
        digit_d = 4'd0;
`ifdef ARGMAX_MARGIN_EN
        second_d = SCORE_MIN;
`endif
      end else if ($signed(in_score) > $signed(max_q)) begin
        // strict compare: ties keep the lower class index
        max_d   = in_score;
        digit_d = idx_q;
`ifdef ARGMAX_MARGIN_EN
        second_d = max_q;
`endif
      end
`ifdef ARGMAX_MARGIN_EN
      else if ($signed(in_score) > $signed(second_q)) begin
        second_d = in_score;
      end
`endif
      idx_d = last ? 4'd0 : idx_q + 4'd1;
    end
    if ((state_q == HOLD) && out_ready && !flush) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      idx_q   <= 4'd0;
      max_q   <= '0;
      digit_q <= 4'd0;
      cnt_q   <= 16'd0;
`ifdef ARGMAX_MARGIN_EN
      second_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
`ifdef ARGMAX_MARGIN_EN
      second_q <= second_d;
`endif
    end
  end

`ifdef ARGMAX_MARGIN_EN
  // Margin computed two bits wider so the clamp to 0 / all-ones is exact
  always_comb begin
    diff = {{2{max_q[SCORE_W-1]}}, max_q} - {{2{second_q[SCORE_W-1]}}, second_q};
    if (diff[SCORE_W+1]) begin
      out_margin = '0;
    end else if (diff[SCORE_W]) begin
      out_margin = '1;
    end else begin
      out_margin = diff[SCORE_W-1:0];
    end
  end
`endif

  assign out_digit = digit_q;
  assign out_score = max_q;
  assign frame_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_digit_argmax.sv
// tb_digit_argmax: directed frames for digit_argmax (NUM_CLASSES=10,
// SCORE_W=16). Define ARGMAX_MARGIN_EN on both files to check out_margin.
module tb_digit_argmax;

  typedef logic [15:0] frame_t [10];
  typedef struct {
    frame_t      s;
    logic [3:0]  dig;
    logic [15:0] sc;
    logic [15:0] mar;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_score = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_digit;
  logic [15:0] out_score;
  logic [15:0] out_margin;
  logic [15:0] frame_cnt;
  logic        dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [35:0] exp_q[$];
  vec_t        tab[7];
  vec_t        fl_vec;

  digit_argmax #(.NUM_CLASSES(10), .SCORE_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_score (out_score),
`ifdef ARGMAX_MARGIN_EN
    .out_margin(out_margin),
`endif
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

`ifndef ARGMAX_MARGIN_EN
  assign out_margin = 16'd0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input frame_t s, input logic [3:0] d,
                              input logic [15:0] sc, input logic [15:0] mar);
    vec_t v;
    v.s = s; v.dig = d; v.sc = sc; v.mar = mar;
    return v;
  endfunction

  // drive classes [from, to) starting at the current falling edge
  task automatic drive_scores(input frame_t s, input int from, input int to);
    for (int i = from; i < to; i++) begin
      in_valid = 1'b1;
      in_score = s[i];
      chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    exp_q.push_back({v.dig, v.sc, v.mar});
    drive_scores(v.s, 0, 10);
  endtask

  // called at the falling edge right after the last transfer
  task automatic check_result(input string name);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_state"}, {31'd0, dbg_state}, 32'd1);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({name, "_digit"}, {28'd0, out_digit}, {28'd0, e[35:32]});
    chk({name, "_score"}, {16'd0, out_score}, {16'd0, e[31:16]});
`ifdef ARGMAX_MARGIN_EN
    chk({name, "_margin"}, {16'd0, out_margin}, {16'd0, e[15:0]});
`endif
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, exp_cnt});
    chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    tab[0] = mk('{16'd5, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd8, 16'd7, 16'd6, 16'd4},
                4'd2, 16'd9, 16'd1);
    tab[1] = mk('{16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C,
                  16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C},
                4'd0, 16'hFF9C, 16'h0000);
    tab[2] = mk('{16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h7FFF},
                4'd9, 16'h7FFF, 16'h7FFF);
    tab[3] = mk('{16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000,
                  16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000},
                4'd1, 16'h7FFF, 16'hFFFF);
    tab[4] = mk('{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9},
                4'd9, 16'd9, 16'd1);
    tab[5] = mk('{16'd1, 16'd2, 16'd3, 16'd20, 16'd4, 16'd5, 16'd6, 16'd7, 16'd20, 16'd0},
                4'd3, 16'd20, 16'd0);
    tab[6] = mk('{16'hFFFB, 16'hFFFF, 16'hFFFD, 16'hFFFE, 16'hFFF7,
                  16'hFFF9, 16'hFFFC, 16'hFFFA, 16'hFFF8, 16'hFFF6},
                4'd1, 16'hFFFF, 16'd1);
    fl_vec = mk('{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd100, 16'd70, 16'd80, 16'd90},
                4'd6, 16'd100, 16'd10);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_digit", {28'd0, out_digit}, 32'd0);
    chk("rst_score", {16'd0, out_score}, 32'd0);
    chk("rst_margin", {16'd0, out_margin}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      send_frame(tab[v]);
      check_result($sformatf("vec%0d", v));
      handshake($sformatf("vec%0d", v));
    end

    // hold for 20 cycles with out_ready low; in_valid must be ignored
    send_frame(tab[0]);
    check_result("hold_start");
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_score = 16'h7FFF;
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_digit", {28'd0, out_digit}, 32'd2);
      chk("hold_score", {16'd0, out_score}, 32'd9);
    end
    in_valid = 1'b0;
    handshake("hold_release");
    send_frame(tab[4]);
    check_result("after_hold");
    handshake("after_hold");

    // flush after 4 scores, same-cycle score discarded
    drive_scores(tab[0].s, 0, 4);
    flush = 1'b1;
    in_valid = 1'b1;
    in_score = 16'h7FFF;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_accum_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
    send_frame(fl_vec);
    check_result("flush_frame");
    handshake("flush_frame");

    // flush in HOLD beats a simultaneous handshake
    send_frame(tab[5]);
    check_result("flush_hold");
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_hold_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
    chk("flush_hold_ready", {31'd0, in_ready}, 32'd1);
    send_frame(tab[2]);
    check_result("post_flush_hold");
    handshake("post_flush_hold");

    // asynchronous reset during class 5
    drive_scores(tab[0].s, 0, 5);
    in_valid = 1'b1;
    in_score = tab[0].s[5];
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_digit", {28'd0, out_digit}, 32'd0);
    chk("mid_rst_score", {16'd0, out_score}, 32'd0);
    chk("mid_rst_margin", {16'd0, out_margin}, 32'd0);
    chk("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    send_frame(tab[6]);
    check_result("after_rst");
    handshake("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
